// File: rtl/ctrl_sequencer.sv
// Program-store sequencer that replays an address range of 7-bit control words
// over a valid/ready handshake, with optional read-after-write bubble insertion.
module ctrl_sequencer #(
    parameter int         DEPTH    = 16,
    parameter int         AW       = 4,
    parameter logic [6:0] NOP_WORD = 7'h00
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [6:0]    prog_data,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic [3:0]    repeat_cnt,
    input  logic          abort,
    input  logic          stall_en,
    output logic [6:0]    ctrl,
    output logic          ctrl_valid,
    input  logic          ctrl_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {IDLE, RUN, BUBBLE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [AW-1:0] first_reg, first_next;
    logic [AW-1:0] last_reg, last_next;
    logic [3:0]    rep_reg, rep_next;
    logic [6:0]    ctrl_reg, ctrl_next;
    logic          valid_reg, valid_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic [6:0]    mem [DEPTH];
    logic          xfer;
    logic          hazard;
    logic [AW-1:0] pc_adv;
    logic [6:0]    adv_word;

    // Store is only writable while idle so a running program cannot be altered.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && prog_we)
            mem[prog_addr] <= prog_data;
    end

    assign xfer     = valid_reg && ctrl_ready;
    assign pc_adv   = (pc_reg == last_reg) ? first_reg : pc_reg + 1'b1;
    assign adv_word = mem[pc_adv];
    // Conservative: either field of the next word may read the register just written.
    assign hazard   = stall_en && ((adv_word[3:2] == ctrl_reg[3:2]) ||
                                   (adv_word[1:0] == ctrl_reg[3:2]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            first_reg <= '0;
            last_reg  <= '0;
            rep_reg   <= '0;
            ctrl_reg  <= NOP_WORD;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            first_reg <= first_next;
            last_reg  <= last_next;
            rep_reg   <= rep_next;
            ctrl_reg  <= ctrl_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        first_next = first_reg;
        last_next  = last_reg;
        rep_next   = rep_reg;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next = RUN;
                    pc_next    = start_addr;
                    first_next = start_addr;
                    last_next  = end_addr;
                    rep_next   = repeat_cnt;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    if (pc_reg == last_reg && rep_reg == 4'd0) begin
                        state_next = DONE;
                    end else begin
                        if (pc_reg == last_reg)
                            rep_next = rep_reg - 4'd1;
                        pc_next    = pc_adv;
                        state_next = hazard ? BUBBLE : RUN;
                    end
                end
            end
            BUBBLE:  state_next = abort ? IDLE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state presents.
    always_comb begin
        ctrl_next  = NOP_WORD;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_next)
            RUN: begin
                ctrl_next  = mem[pc_next];
                valid_next = 1'b1;
                busy_next  = 1'b1;
            end
            BUBBLE:  busy_next = 1'b1;
            DONE:    done_next = 1'b1;
            default: ;
        endcase
    end

    assign ctrl       = ctrl_reg;
    assign ctrl_valid = valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign pc         = pc_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer: expected word stream is built from the
// address range, repeat count and hazard rule, then matched against every transfer.
module tb_ctrl_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [6:0]    prog_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [3:0]    repeat_cnt = '0;
    logic          abort = 1'b0;
    logic          stall_en = 1'b0;
    logic          ctrl_ready = 1'b0;
    logic [6:0]    ctrl;
    logic          ctrl_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int checks = 0;
    int errors = 0;
    logic [6:0] mem_model [DEPTH];

    ctrl_sequencer #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(7'h00)) dut (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .repeat_cnt(repeat_cnt), .abort(abort),
        .stall_en(stall_en), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready), .busy(busy), .done(done), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic load_word(input int a, input logic [6:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic load_random_store();
        for (int i = 0; i < DEPTH; i++)
            load_word(i, 7'($urandom_range(0, 127)));
    endtask

    function automatic bit hazard_of(input logic [6:0] prev, input logic [6:0] nxt, input bit st);
        return st && ((nxt[3:2] == prev[3:2]) || (nxt[1:0] == prev[3:2]));
    endfunction

    // Drives one run from IDLE and checks every presented word, bubble and the done pulse.
    task automatic test_run(input string name, input int s, input int e, input int rep,
                            input bit st, input int ready_pct, input int hold_at, input int abort_at);
        int  addrs[$];
        int  a, n, idx, cyc, held;
        bit  exp_bubble, r;
        addrs.delete();
        for (int p = 0; p <= rep; p++) begin
            a = s;
            forever begin
                addrs.push_back(a);
                if (a == e) break;
                a = (a + 1) % DEPTH;
            end
        end
        n = addrs.size();
        start_addr = AW'(s);
        end_addr   = AW'(e);
        repeat_cnt = 4'(rep);
        stall_en   = st;
        ctrl_ready = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; held = 0; exp_bubble = 1'b0;
        while (idx < n) begin
            cyc++;
            if (cyc > 4000) begin
                checks++; errors++;
                $display("FAIL %s timeout: transferred %0d, required %0d", name, idx, n);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                @(negedge clk);
                return;
            end
            if (exp_bubble) begin
                checks++;
                if (ctrl_valid !== 1'b0 || ctrl !== 7'h00 || busy !== 1'b1 || 32'(pc) !== addrs[idx]) begin
                    errors++;
                    $display("FAIL %s bubble idx=%0d: valid=%b ctrl=%h busy=%b pc=%0d, required valid=0 ctrl=00 busy=1 pc=%0d",
                             name, idx, ctrl_valid, ctrl, busy, pc, addrs[idx]);
                end
                exp_bubble = 1'b0;
                ctrl_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                continue;
            end
            checks++;
            if (ctrl_valid !== 1'b1 || ctrl !== mem_model[addrs[idx]] || 32'(pc) !== addrs[idx] ||
                busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s word idx=%0d: valid=%b ctrl=%h pc=%0d busy=%b done=%b, required valid=1 ctrl=%h pc=%0d busy=1 done=0",
                         name, idx, ctrl_valid, ctrl, pc, busy, done, mem_model[addrs[idx]], addrs[idx]);
            end
            if (idx == hold_at && held < 3) begin
                r = 1'b0;
                held++;
            end else begin
                r = ($urandom_range(1, 100) <= ready_pct);
            end
            ctrl_ready = r;
            if (idx == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                ctrl_ready = 1'b0;
                checks++;
                if (ctrl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ctrl !== 7'h00) begin
                    errors++;
                    $display("FAIL %s abort: valid=%b busy=%b done=%b ctrl=%h, required 0 0 0 00",
                             name, ctrl_valid, busy, done, ctrl);
                end
                @(negedge clk);
                checks++;
                if (ctrl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s after_abort: valid=%b busy=%b done=%b, required 0 0 0",
                             name, ctrl_valid, busy, done);
                end
                $display("run %s: s=%0d e=%0d rep=%0d stall=%0d aborted at word %0d", name, s, e, rep, st, idx);
                return;
            end
            @(negedge clk);
            if (r) begin
                idx++;
                if (idx < n)
                    exp_bubble = hazard_of(mem_model[addrs[idx-1]], mem_model[addrs[idx]], st);
            end
        end
        ctrl_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ctrl_valid !== 1'b0 || ctrl !== 7'h00) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b valid=%b ctrl=%h, required done=1 busy=0 valid=0 ctrl=00",
                     name, done, busy, ctrl_valid, ctrl);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ctrl_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b busy=%b valid=%b, required 0 0 0",
                     name, done, busy, ctrl_valid);
        end
        $display("run %s: s=%0d e=%0d rep=%0d stall=%0d words=%0d", name, s, e, rep, st, n);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ctrl !== 7'h00 || ctrl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin
            errors++;
            $display("FAIL reset: ctrl=%h valid=%b busy=%b done=%b pc=%0d, required 00 0 0 0 0",
                     ctrl, ctrl_valid, busy, done, pc);
        end
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        load_random_store();
        load_word(0, 7'h11); load_word(1, 7'h22); load_word(2, 7'h33); load_word(3, 7'h44);
        test_run("basic", 0, 3, 0, 1'b0, 100, -1, -1);
    endtask

    task automatic test_backpressure();
        test_run("backpressure", 0, 3, 0, 1'b0, 100, 1, -1);
    endtask

    task automatic test_wrap_repeat();
        test_run("wrap_repeat", 14, 1, 1, 1'b0, 80, -1, -1);
    endtask

    task automatic test_hazard();
        load_word(0, 7'b0000100);
        load_word(1, 7'b0000001);
        test_run("hazard_on", 0, 1, 0, 1'b1, 100, -1, -1);
        test_run("hazard_off", 0, 1, 0, 1'b0, 100, -1, -1);
    endtask

    task automatic test_single();
        test_run("single", 5, 5, 2, 1'b1, 70, -1, -1);
        test_run("single_nostall", 9, 9, 3, 1'b0, 100, -1, -1);
    endtask

    task automatic test_abort();
        load_word(0, 7'h11); load_word(1, 7'h22); load_word(2, 7'h33); load_word(3, 7'h44);
        test_run("abort", 0, 3, 0, 1'b0, 100, -1, 2);
        test_run("after_abort", 0, 3, 0, 1'b0, 100, -1, -1);
    endtask

    task automatic test_async_reset();
        start_addr = 4'd5; end_addr = 4'd4; repeat_cnt = 4'd0; stall_en = 1'b0;
        ctrl_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== 7'h00 || ctrl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: ctrl=%h valid=%b busy=%b done=%b pc=%0d, required 00 0 0 0 0",
                     ctrl, ctrl_valid, busy, done, pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        $display("async_reset: outputs cleared between edges");
        // Write attempt while running must not reach the store.
        start_addr = 4'd0; end_addr = 4'd3; repeat_cnt = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = mem_model[1] ^ 7'h7f;
        @(negedge clk);
        prog_we = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        test_run("store_unchanged", 0, 3, 0, 1'b0, 100, -1, -1);
    endtask

    task automatic test_random();
        int s, e, rep, pct;
        bit st;
        for (int it = 0; it < 10; it++) begin
            load_random_store();
            s   = $urandom_range(0, DEPTH-1);
            e   = $urandom_range(0, DEPTH-1);
            rep = $urandom_range(0, 2);
            st  = 1'($urandom_range(0, 1));
            pct = $urandom_range(40, 100);
            test_run("random", s, e, rep, st, pct, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_repeat();
        test_hazard();
        test_single();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Issues 7-bit datapath instruction words (ctrl[6:0]) to the register-file/ALU/shifter control decoder.
- Word layout: opcode[6:4], write/B address[3:2], A address or shift control[1:0].
- Holds a small host-loaded program store and replays an address range with a repeat count, using a valid/ready handshake.
- Optionally inserts a one-cycle bubble on read-after-write register hazards.

Parameters:
- DEPTH, 16, program store entries (power of two)
- AW, 4, program address width (log2 DEPTH)
- NOP_WORD, 7'h00, word driven on ctrl whenever ctrl_valid is low

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- prog_we  input  1  program store write strobe
- prog_addr  input  AW  program store write address
- prog_data  input  7  program word to write
- start  input  1  one-cycle pulse that begins a run
- start_addr  input  AW  first word of the run
- end_addr  input  AW  last word of the run, inclusive
- repeat_cnt  input  4  extra passes over the range (0 means one pass)
- abort  input  1  terminates the run
- stall_en  input  1  enables hazard bubble insertion
- ctrl  output  7  instruction word to the control decoder
- ctrl_valid  output  1  ctrl holds a valid word
- ctrl_ready  input  1  decoder accepts the word this cycle
- busy  output  1  run in progress
- done  output  1  one-cycle pulse when a run completes normally
- pc  output  AW  address of the word currently presented

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, ctrl=NOP_WORD, ctrl_valid=0, busy=0, done=0, pc=0, repeat counter=0.
  - Program store contents are not reset.
- States: IDLE, RUN, BUBBLE, DONE. All outputs are registered.
- Program store writes:
  - In IDLE, prog_we writes prog_data to mem[prog_addr] on the clock edge.
  - prog_we is ignored in every other state.
- Starting a run:
  - IDLE and start=1: latch start_addr, end_addr and repeat_cnt; set pc=start_addr; go to RUN.
  - The next cycle shows ctrl=mem[start_addr], ctrl_valid=1, busy=1.
  - Latency from start to first valid word is 1 cycle.
  - start is ignored when not in IDLE.
- Handshake:
  - A transfer occurs on a cycle with ctrl_valid=1 and ctrl_ready=1.
  - While ctrl_valid=1 and ctrl_ready=0, ctrl and pc hold stable.
  - ctrl_valid never drops without a transfer, except on abort.
- Advancing after a transfer in RUN:
  - pc==end_addr and repeat counter==0: go to DONE, ctrl_valid=0, ctrl=NOP_WORD.
  - pc==end_addr and repeat counter>0: decrement the counter; next pc=start_addr.
  - Otherwise next pc=pc+1, wrapping from DEPTH-1 to 0. start_addr>end_addr is therefore legal and runs through the wrap.
  - Single-word range (start_addr==end_addr): the word issues repeat_cnt+1 times.
- Hazard bubble:
  - Condition: stall_en=1 and the next word's bits[3:2] or bits[1:0] equal the transferred word's bits[3:2]. Compare conservatively and ignore the opcode.
  - On a hazard, go to BUBBLE for exactly one cycle: ctrl_valid=0, ctrl=NOP_WORD, pc already advanced.
  - Then return to RUN presenting the next word.
  - No bubble is inserted when the run ends on that transfer.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Abort:
  - abort=1 in any non-IDLE state: next cycle state=IDLE, ctrl_valid=0, ctrl=NOP_WORD, busy=0, done=0.
  - A transfer in the same cycle as abort counts, but nothing further issues.
  - abort has priority over start.
- busy is 1 in RUN and BUBBLE, and 0 in IDLE and DONE.

Test Plan:
- Load mem[0..3]=7'h11,7'h22,7'h33,7'h44; start with start_addr=0, end_addr=3, repeat_cnt=0, ctrl_ready=1, stall_en=0 -> 4 consecutive valid words 11,22,33,44 starting 1 cycle after start, then done pulse, busy=0.
- Same program, ctrl_ready low for 3 cycles while presenting 7'h22 -> ctrl=22 and pc=1 held; each word transferred exactly once.
- start_addr=14, end_addr=1, DEPTH=16, repeat_cnt=1 -> pc sequence 14,15,0,1,14,15,0,1, then done.
- stall_en=1, mem[0]=7'b0000100 (write reg1), mem[1]=7'b0000001 (reads reg1) -> transfer of word 0, one cycle ctrl_valid=0 with ctrl=00, then word 1. With stall_en=0 there is no bubble.
- Abort asserted mid-run at pc=2 -> next cycle ctrl_valid=0, busy=0, no done pulse; a following start runs normally.
- reset_n pulsed low mid-run (asynchronously, between edges) -> outputs go immediately to reset values; prog_we in RUN is ignored and the store is unchanged, verified by rerun.
